fc_argmax: RTL
==============

# fc_argmax

Classifier back-end for the binary MNIST network. It sits directly downstream of the fully-connected layer and accepts the 10 signed FC scores as one parallel vector over a valid/ready handshake. It scans the scores sequentially, one per cycle, and returns the winning digit on `class_out` over a valid/ready handshake, together with the winning score and a tie flag.

## Interface
- `NUM_CLASSES`, 10: number of FC outputs scanned; legal range 2..16.
- `SCORE_W`, 17: width of each FC score, signed two's complement.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `score_in_valid` input 1: the score vector is valid.
- `score_in_ready` output 1: the block can accept a vector.
- `score_in` input `[0:NUM_CLASSES-1][SCORE_W-1:0]`: FC scores; index = digit.
- `class_out_valid` output 1: a result is held.
- `class_out_ready` input 1: the consumer accepts the result.
- `class_out` output 4: winning digit index.
- `class_score` output `SCORE_W`: the winning score.
- `class_tie` output 1: another index holds a score equal to the winning score.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset state is IDLE.
- IDLE:
  - `score_in_ready` = 1.
  - On `score_in_valid && score_in_ready`, capture the full vector into an internal buffer.
  - Initialise best_idx = 0, best = score[0], tie = 0, idx = 1, then go to SCAN.
- SCAN: each cycle, compare buf[idx] with best as signed values.
  - If strictly greater: best = buf[idx], best_idx = idx, tie = 0.
  - If equal: tie = 1.
  - If less: no change.
  - When idx == NUM_CLASSES-1, go to DONE after this compare. Otherwise idx increments.
- Ties therefore resolve to the lowest index. `class_tie` reflects equality with the final maximum only.
- DONE:
  - `class_out_valid` = 1.
  - `class_out`, `class_score` and `class_tie` are driven from registers and held stable.
  - On `class_out_valid && class_out_ready`, go to IDLE.
- `score_in_ready` is 0 in SCAN and DONE. Upstream holds its vector.
- `score_in` is sampled only on the accepting edge. Changes afterwards have no effect.
- Comparisons are full-width signed `SCORE_W` comparisons, with no truncation or saturation. `class_out` is zero-extended to 4 bits.

## Timing
- Reset values while `rst` is asserted, applied asynchronously:
  - state = IDLE, `score_in_ready` = 1.
  - `class_out_valid` = 0, `class_out` = 0, `class_score` = 0, `class_tie` = 0.
  - idx = 0, buffer contents don't-care.
- Latency: vector accepted at edge k. Compares happen at edges k+1 .. k+NUM_CLASSES-1. `class_out_valid` rises after edge k+NUM_CLASSES-1, i.e. 9 cycles after acceptance for the default configuration.
- Throughput: at most one vector per NUM_CLASSES+1 cycles, with `class_out_ready` tied high.
  - Output handshake at edge m returns the FSM to IDLE.
  - The next vector can be accepted at edge m+1, not at edge m.
- Backpressure: `class_out_valid` stays high and the outputs stay unchanged for as long as `class_out_ready` = 0. There is no timeout.
- `score_in_valid` high during SCAN or DONE is ignored and is not queued.
- Reset mid-SCAN or mid-DONE aborts immediately. A pending result is discarded and never presented.
- `class_out_ready` high while `class_out_valid` = 0 has no effect.

## Structure
- Shared package `bnn_pkg` holds:
  - `NUM_CLASSES` and `SCORE_W` defaults.
  - The `score_t` typedef (signed `[SCORE_W-1:0]`).
  - The `argmax_state_e` enum {IDLE, SCAN, DONE}.
  - A `CLASS_W` = 4 constant.
- The FC layer imports `score_t` from the same package.
- Single module. The signed compare is one expression and does not warrant a sub-module.
- An elaboration-time check fails if NUM_CLASSES < 2 or > 16.

## Test plan
- Distinct maximum: scores {5,-3,12,0,7,1,2,40,9,-8}, ready held high → `class_out`=7, `class_score`=40, `class_tie`=0. Valid asserts exactly 9 cycles after acceptance.
- All equal: all scores = -960 → `class_out`=0, `class_score`=-960, `class_tie`=1.
- Signed extremes and last index: scores {-65536 ×9, 65535 at index 9} → `class_out`=9, `class_score`=65535. Then run {3,…,3,1} → `class_out`=0, `class_tie`=1.
- Tie cleared by a larger score: {4,4,9,0,0,0,0,0,0,0} → `class_out`=2, `class_tie`=0.
- Backpressure and ignored input:
  - Hold `class_out_ready`=0 for 20 cycles while toggling `score_in` and `score_in_valid`.
  - Outputs stay stable and `score_in_ready`=0 throughout.
  - Release ready → one handshake, `score_in_ready`=1 on the next cycle.
- Reset mid-SCAN: assert `rst` 4 cycles after acceptance → `class_out_valid` stays 0 and all outputs read 0. After release, a new vector completes normally with the correct class.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared types and defaults for the binary MNIST network back-end.
package bnn_pkg;
    localparam int NUM_CLASSES_DEFAULT = 10;
    localparam int SCORE_W_DEFAULT     = 17;
    localparam int CLASS_W             = 4;

    typedef logic signed [SCORE_W_DEFAULT-1:0] score_t;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_e;
endpackage

// File: rtl/fc_argmax.sv
// fc_argmax: sequential signed argmax over the FC score vector, lowest index wins ties.
module fc_argmax
    import bnn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT,
    parameter int SCORE_W     = SCORE_W_DEFAULT
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 score_in_valid,
    output logic                                 score_in_ready,
    input  logic [0:NUM_CLASSES-1][SCORE_W-1:0]  score_in,
    output logic                                 class_out_valid,
    input  logic                                 class_out_ready,
    output logic [CLASS_W-1:0]                   class_out,
    output logic [SCORE_W-1:0]                   class_score,
    output logic                                 class_tie
);
    typedef logic signed [SCORE_W-1:0] sc_t;

    localparam logic [CLASS_W-1:0] LAST = CLASS_W'(NUM_CLASSES - 1);

    if (NUM_CLASSES < 2 || NUM_CLASSES > 16) begin : g_bad_num_classes
        $error("fc_argmax: NUM_CLASSES must be in 2..16");
    end

    argmax_state_e                        state_q, state_d;
    logic [0:NUM_CLASSES-1][SCORE_W-1:0]  buf_q, buf_d;
    logic [CLASS_W-1:0]                   idx_q, idx_d;
    logic [CLASS_W-1:0]                   best_idx_q, best_idx_d;
    sc_t                                  best_q, best_d;
    logic                                 tie_q, tie_d;
    sc_t                                  cur;
    logic                                 gt;

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        tie_d      = tie_q;
        cur        = buf_q[idx_q];
        gt         = cur > best_q;
        case (state_q)
            IDLE: begin
                if (score_in_valid) begin
                    buf_d      = score_in;
                    best_d     = score_in[0];
                    best_idx_d = '0;
                    tie_d      = 1'b0;
                    idx_d      = CLASS_W'(1);
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_d     = gt ? cur : best_q;
                best_idx_d = gt ? idx_q : best_idx_q;
                tie_d      = gt ? 1'b0 : (tie_q | (cur == best_q));
                idx_d      = (idx_q == LAST) ? '0 : idx_q + CLASS_W'(1);
                state_d    = (idx_q == LAST) ? DONE : SCAN;
            end
            DONE:    state_d = class_out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            tie_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            tie_q      <= tie_d;
        end
    end

    // The score buffer has no reset: its contents are only read after a capture.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign score_in_ready  = (state_q == IDLE);
    assign class_out_valid = (state_q == DONE);
    assign class_out       = best_idx_q;
    assign class_score     = best_q;
    assign class_tie       = tie_q;
endmodule
